// File: rtl/dfr_reservoir_pipe.sv
// ============================================================================
// Module   : dfr_reservoir_pipe
// Brief    : Delayed-feedback reservoir node chain fed through an external
//            activation memory of configurable read latency.
//            Optional macro DFR_ADDR_SAT_EN saturates the memory address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfr_reservoir_pipe #(
  parameter int NUM_VIRTUAL_NODES = 100,
  parameter int DATA_WIDTH        = 32,
  parameter int NODE_DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH        = 16,
  parameter int ACT_LATENCY       = 2,
  parameter int FB_SHIFT          = 2,
  parameter int OUT_SHIFT         = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                din,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                dout,
  output logic [ADDR_WIDTH-1:0]                act_addr,
  input  logic [NODE_DATA_WIDTH-1:0]           act_data,
  input  logic                                 load_node,
  input  logic [NODE_DATA_WIDTH-1:0]           load_node_din,
  input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0] node_sel,
  output logic [NODE_DATA_WIDTH-1:0]           node_dout,
  output logic                                 busy
);

  localparam int c_sel_w = $clog2(NUM_VIRTUAL_NODES);
  localparam int c_cnt_w = (ACT_LATENCY > 1) ? $clog2(ACT_LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACT_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACT_WAIT = 2'd1,
    S_SHIFT    = 2'd2
  } state_t;

  state_t                     r_state;
  logic [c_cnt_w-1:0]         r_cnt;
  logic                       r_out_valid;
  logic [ADDR_WIDTH-1:0]      r_act_addr;
  logic [NODE_DATA_WIDTH-1:0] r_node [NUM_VIRTUAL_NODES];

  logic [DATA_WIDTH-1:0]      w_fb;
  logic [DATA_WIDTH-1:0]      w_sum;
  logic [ADDR_WIDTH-1:0]      w_addr;
  logic                       w_sum_unused;
  logic                       w_idle;
  logic                       w_accept;

  assign w_idle   = (r_state == S_IDLE);
  assign in_ready = w_idle & ~load_node & ~clear;
  assign w_accept = in_valid & in_ready;
  assign busy     = ~w_idle;

  assign w_fb  = DATA_WIDTH'(r_node[NUM_VIRTUAL_NODES-1]) << FB_SHIFT;
  assign w_sum = din + w_fb;
  assign w_sum_unused = |(w_sum >> ADDR_WIDTH);

`ifdef DFR_ADDR_SAT_EN
  assign w_addr = w_sum_unused ? {ADDR_WIDTH{1'b1}} : w_sum[ADDR_WIDTH-1:0];
`else
  assign w_addr = w_sum[ADDR_WIDTH-1:0];
`endif

  assign dout      = DATA_WIDTH'(r_node[NUM_VIRTUAL_NODES-1]) << OUT_SHIFT;
  assign out_valid = r_out_valid;
  assign act_addr  = r_act_addr;

  // Index decode by loop so selects beyond the chain read back as zero
  always_comb begin
    node_dout = '0;
    for (int i = 0; i < NUM_VIRTUAL_NODES; i++) begin
      if (node_sel == c_sel_w'(i)) node_dout = r_node[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_act_addr  <= '0;
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++) r_node[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (clear) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        for (int i = 0; i < NUM_VIRTUAL_NODES; i++) r_node[i] <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_act_addr <= w_addr;
              r_cnt      <= '0;
              r_state    <= S_ACT_WAIT;
            end else if (load_node) begin
              for (int i = 0; i < NUM_VIRTUAL_NODES; i++) begin
                if (node_sel == c_sel_w'(i)) r_node[i] <= load_node_din;
              end
            end
          end
          S_ACT_WAIT: begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_cnt_last) r_state <= S_SHIFT;
          end
          S_SHIFT: begin
            r_node[0] <= act_data;
            for (int i = 1; i < NUM_VIRTUAL_NODES; i++) r_node[i] <= r_node[i-1];
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dfr_reservoir_pipe.sv
// ============================================================================
// Module   : tb_dfr_reservoir_pipe
// Brief    : Directed self-checking bench for dfr_reservoir_pipe (N=4,
//            activation memory returns addr[11:0] after two cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dfr_reservoir_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] din = '0;
  logic        out_valid;
  logic [31:0] dout;
  logic [15:0] act_addr;
  logic [11:0] act_data = '0;
  logic        load_node = 1'b0;
  logic [11:0] load_node_din = '0;
  logic [1:0]  node_sel = '0;
  logic [11:0] node_dout;
  logic        busy;

  logic [11:0] mem_s1 = '0;

  int checks = 0;
  int failures = 0;

  dfr_reservoir_pipe #(
    .NUM_VIRTUAL_NODES(4), .DATA_WIDTH(32), .NODE_DATA_WIDTH(12),
    .ADDR_WIDTH(16), .ACT_LATENCY(2), .FB_SHIFT(2), .OUT_SHIFT(4)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .din(din), .out_valid(out_valid), .dout(dout),
    .act_addr(act_addr), .act_data(act_data), .load_node(load_node),
    .load_node_din(load_node_din), .node_sel(node_sel),
    .node_dout(node_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Two-cycle activation memory: data = addr[11:0]
  always @(posedge clk) begin
    mem_s1   <= act_addr[11:0];
    act_data <= mem_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_node(input int idx, input logic [11:0] exp, input string tag);
    node_sel = 2'(idx);
    #1;
    chk(tag, 32'(node_dout), 32'(exp));
  endtask

  task automatic load(input int idx, input logic [11:0] val);
    load_node = 1'b1;
    node_sel = 2'(idx);
    load_node_din = val;
    step();
    load_node = 1'b0;
    #1;
  endtask

  // Called one cycle after the accepting edge; out_valid is due 3 edges later
  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'd3);
  endtask

  task automatic send(input logic [31:0] d, input logic [15:0] exp_addr, input string tag);
    din = d;
    in_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "_addr"}, 32'(act_addr), 32'(exp_addr));
    wait_out({tag, "_lat"});
  endtask

  initial begin
    logic [15:0] exp_addr3;
    logic [11:0] exp_n3;
`ifdef DFR_ADDR_SAT_EN
    exp_addr3 = 16'hFFFF;
    exp_n3    = 12'hFFF;
`else
    exp_addr3 = 16'h03FF;
    exp_n3    = 12'h3FF;
`endif

    // Reset state
    step();
    step();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_addr", 32'(act_addr), 32'd0);
    rst = 1'b0;
    step();

    // 1: single sample, exact latency
    din = 32'h10;
    in_valid = 1'b1;
    #1;
    chk("t1_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t1_addr", 32'(act_addr), 32'h10);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_busy", 32'(in_ready), 32'd0);
    chk("t1_ov_t1", 32'(out_valid), 32'd0);
    step();
    chk("t1_ov_t2", 32'(out_valid), 32'd0);
    step();
    chk("t1_ov_t3", 32'(out_valid), 32'd0);
    step();
    chk("t1_ov_t4", 32'(out_valid), 32'd1);
    chk("t1_ready_t4", 32'(in_ready), 32'd1);
    step();
    chk("t1_ov_t5", 32'(out_valid), 32'd0);
    chk_node(0, 12'h010, "t1_n0");
    chk_node(1, 12'h000, "t1_n1");
    chk_node(3, 12'h000, "t1_n3");

    // 2: feedback from preloaded oldest node
    load(3, 12'hFFF);
    chk("t2_dout", dout, 32'h0000_FFF0);
    send(32'h1, 16'h3FFD, "t2");
    chk_node(0, 12'hFFD, "t2_n0");
    chk_node(1, 12'h010, "t2_n1");
    chk("t2_dout_after", dout, 32'd0);

    // 3: sum overflows address width
    load(3, 12'h100);
    send(32'hFFFF, exp_addr3, "t3");
    chk_node(0, exp_n3, "t3_n0");
    chk_node(1, 12'hFFD, "t3_n1");

    // clear while idle: nodes zero, address kept
    clear = 1'b1;
    #1;
    chk("clr_ready", 32'(in_ready), 32'd0);
    step();
    clear = 1'b0;
    chk_node(0, 12'h000, "clr_n0");
    chk_node(1, 12'h000, "clr_n1");
    chk("clr_addr", 32'(act_addr), 32'(exp_addr3));

    // 4: back-to-back samples, in_valid held high
    for (int k = 1; k <= 4; k++) begin
      din = 32'(k);
      in_valid = 1'b1;
      #1;
      chk("t4_ready", 32'(in_ready), 32'd1);
      step();
      wait_out("t4_lat");
    end
    in_valid = 1'b0;
    chk_node(0, 12'd4, "t4_n0");
    chk_node(1, 12'd3, "t4_n1");
    chk_node(2, 12'd2, "t4_n2");
    chk_node(3, 12'd1, "t4_n3");
    chk("t4_dout", dout, 32'h10);

    // 5: load beats a simultaneous sample
    load_node = 1'b1;
    node_sel = 2'd1;
    load_node_din = 12'h123;
    din = 32'd5;
    in_valid = 1'b1;
    #1;
    chk("t5_ready_load", 32'(in_ready), 32'd0);
    step();
    load_node = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t5_addr", 32'(act_addr), 32'd9);
    wait_out("t5_lat");
    chk_node(0, 12'd9, "t5_n0");
    chk_node(1, 12'd4, "t5_n1");
    chk_node(2, 12'h123, "t5_n2");
    chk("t5_dout", dout, 32'h20);

    // 6a: clear during ACT_WAIT
    din = 32'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t6_addr", 32'(act_addr), 32'hF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_addr_kept", 32'(act_addr), 32'hF);
    for (int c = 0; c < 5; c++) begin
      chk("t6_no_ov", 32'(out_valid), 32'd0);
      step();
    end
    chk_node(0, 12'h000, "t6_n0");
    chk_node(2, 12'h000, "t6_n2");

    // 6b: async reset during ACT_WAIT
    load(0, 12'h055);
    din = 32'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t6r_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6r_busy", 32'(busy), 32'd0);
    chk("t6r_addr", 32'(act_addr), 32'd0);
    chk_node(0, 12'h000, "t6r_n0");
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t6r_no_ov", 32'(out_valid), 32'd0);
    end

    // normal operation resumes after reset
    send(32'h20, 16'h20, "t7");
    chk_node(0, 12'h020, "t7_n0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
